// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: grant-state encoding, grant codes and default widths shared by the
// SDRAM port arbiter and its interface.
package sdram_arb_pkg;
    localparam int DEF_ADDR_W = 25;
    localparam int DEF_DATA_W = 16;
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_RD   = 2'b01;
    localparam logic [1:0] GNT_WR   = 2'b10;
    // State values double as the oGRANT code so the grant output is the state register itself.
    typedef enum logic [1:0] {
        IDLE     = GNT_NONE,
        GRANT_RD = GNT_RD,
        GRANT_WR = GNT_WR
    } state_e;
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: bundle of reader, writer and controller-side signals of the arbiter.
// master drives requests and controller responses; slave is the arbiter's view.
interface sdram_port_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_wait;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_wait;
    logic [ADDR_W-1:0] sd_addr;
    logic              sd_read_n;
    logic              sd_write_n;
    logic [DATA_W-1:0] sd_wdata;
    logic              sd_wait;
    logic [DATA_W-1:0] sd_rdata;
    logic              sd_rvalid;
    logic [1:0]        grant;
    logic [3:0]        pending;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, sd_wait, sd_rdata, sd_rvalid,
        input  rd_wait, rd_data, rd_valid, wr_wait, sd_addr, sd_read_n, sd_write_n, sd_wdata,
               grant, pending
    );
    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, sd_wait, sd_rdata, sd_rvalid,
        output rd_wait, rd_data, rd_valid, wr_wait, sd_addr, sd_read_n, sd_write_n, sd_wdata,
               grant, pending
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up/down counter that saturates at 0 and at max_i; clr_i wins, inc+dec together hold.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb
        cnt_d = clr_i ? '0
              : (inc_i && !dec_i && cnt_q < max_i) ? cnt_q + 1'b1
              : (dec_i && !inc_i && cnt_q != '0) ? cnt_q - 1'b1
              : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller port between a reader and a writer,
// with bounded bursts per owner and a cap on outstanding reads.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int MAX_PENDING    = 8,
    parameter int RD_BURST_LIMIT = 32,
    parameter int WR_BURST_LIMIT = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iRD_EN,
    input  logic [ADDR_W-1:0] iRD_ADDR,
    output logic              oRD_WAIT_REQUEST,
    output logic [DATA_W-1:0] oRD_DATA,
    output logic              oRD_DATAVALID,
    input  logic              iWR_EN,
    input  logic [ADDR_W-1:0] iWR_ADDR,
    input  logic [DATA_W-1:0] iWR_DATA,
    output logic              oWR_WAIT_REQUEST,
    output logic [ADDR_W-1:0] oSDRAM_ADDR,
    output logic              oSDRAM_READ_N,
    output logic              oSDRAM_WRITE_N,
    output logic [DATA_W-1:0] oSDRAM_WRITEDATA,
    input  logic              iSDRAM_WAIT_REQUEST,
    input  logic [DATA_W-1:0] iSDRAM_READDATA,
    input  logic              iSDRAM_READDATAVALID,
    output logic [1:0]        oGRANT,
    output logic [3:0]        oPENDING
);
    localparam int BL = (RD_BURST_LIMIT > WR_BURST_LIMIT) ? RD_BURST_LIMIT : WR_BURST_LIMIT;
    localparam int BW = $clog2(BL + 1);

    state_e        state_q, state_d;
    logic [3:0]    pend_cnt;
    logic [BW-1:0] burst_cnt;
    logic          in_rd, in_wr, pend_ok, acc_rd, acc_wr, rd_last, wr_last;

    assign in_rd   = state_q == GRANT_RD;
    assign in_wr   = state_q == GRANT_WR;
    assign pend_ok = pend_cnt < 4'(MAX_PENDING);
    assign acc_rd  = in_rd && iRD_EN && pend_ok && !iSDRAM_WAIT_REQUEST;
    assign acc_wr  = in_wr && iWR_EN && !iSDRAM_WAIT_REQUEST;
    // The command accepted this cycle is the last of the burst once the count sits at limit-1 or above.
    assign rd_last = burst_cnt >= BW'(RD_BURST_LIMIT - 1);
    assign wr_last = burst_cnt >= BW'(WR_BURST_LIMIT - 1);

    assign oSDRAM_READ_N    = !(in_rd && iRD_EN && pend_ok);
    assign oSDRAM_WRITE_N   = !(in_wr && iWR_EN);
    assign oRD_WAIT_REQUEST = !(in_rd && pend_ok && !iSDRAM_WAIT_REQUEST);
    assign oWR_WAIT_REQUEST = !(in_wr && !iSDRAM_WAIT_REQUEST);
    assign oSDRAM_ADDR      = in_wr ? iWR_ADDR : iRD_ADDR;
    assign oSDRAM_WRITEDATA = iWR_DATA;
    assign oRD_DATA         = iSDRAM_READDATA;
    assign oRD_DATAVALID    = iSDRAM_READDATAVALID;
    assign oGRANT           = state_q;
    assign oPENDING         = pend_cnt;

    // A switch away from an owner only happens on an accepted command, so a stalled one keeps the grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     state_d = iRD_EN ? GRANT_RD : (iWR_EN ? GRANT_WR : IDLE);
            GRANT_RD: state_d = !iRD_EN ? IDLE : ((acc_rd && rd_last && iWR_EN) ? GRANT_WR : GRANT_RD);
            GRANT_WR: state_d = !iWR_EN ? IDLE : ((acc_wr && wr_last && iRD_EN) ? GRANT_RD : GRANT_WR);
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST)
        if (iRST) state_q <= IDLE;
        else state_q <= state_d;

    sat_counter #(.W(4)) u_pending (
        .clk   (iCLK),
        .rst   (iRST),
        .clr_i (1'b0),
        .inc_i (acc_rd),
        .dec_i (iSDRAM_READDATAVALID),
        .max_i (4'(MAX_PENDING)),
        .cnt_o (pend_cnt)
    );

    sat_counter #(.W(BW)) u_burst (
        .clk   (iCLK),
        .rst   (iRST),
        .clr_i (state_d != state_q),
        .inc_i (acc_rd || acc_wr),
        .dec_i (1'b0),
        .max_i (in_wr ? BW'(WR_BURST_LIMIT) : BW'(RD_BURST_LIMIT)),
        .cnt_o (burst_cnt)
    );
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: randomized and directed stimulus against a cycle-level reference model,
// with read/write scoreboards matching requester-side transactions to controller-side ones.
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int MAXP = 8;
    localparam int LIM = 32;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MAXP), .RD_BURST_LIMIT(LIM), .WR_BURST_LIMIT(LIM)
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iRD_EN(bus.rd_en), .iRD_ADDR(bus.rd_addr), .oRD_WAIT_REQUEST(bus.rd_wait),
        .oRD_DATA(bus.rd_data), .oRD_DATAVALID(bus.rd_valid),
        .iWR_EN(bus.wr_en), .iWR_ADDR(bus.wr_addr), .iWR_DATA(bus.wr_data),
        .oWR_WAIT_REQUEST(bus.wr_wait),
        .oSDRAM_ADDR(bus.sd_addr), .oSDRAM_READ_N(bus.sd_read_n), .oSDRAM_WRITE_N(bus.sd_write_n),
        .oSDRAM_WRITEDATA(bus.sd_wdata), .iSDRAM_WAIT_REQUEST(bus.sd_wait),
        .iSDRAM_READDATA(bus.sd_rdata), .iSDRAM_READDATAVALID(bus.sd_rvalid),
        .oGRANT(bus.grant), .oPENDING(bus.pending)
    );

    always #5 iCLK = ~iCLK;

    int n_chk = 0, n_pass = 0;
    int n_rd_acc = 0, n_wr_acc = 0, n_wr_pulse = 0, rd_goal = 0, wr_goal = 0;
    int rv_given = 0, rv_allow = 0, stall_at = -1, stall_seen = 0, stall_target = 0, stale_n = 0;
    int m_own = 0, m_burst = 0, m_pend = 0, nown;
    logic gappy = 1'b0, rnd_wait = 1'b0, hold_rv = 1'b0, pok, ard, awr;
    logic [AW-1:0] rd_base = 25'h1_0000, wr_base = 25'h0_A000;
    logic [DW-1:0] exp_rd[$];
    logic [AW+DW-1:0] exp_wr[$];
    logic [AW-1:0] ctrl_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] rdat(input logic [AW-1:0] a);
        return a[15:0] ^ {a[24:18], 9'h15A};
    endfunction

    // Requesters and SDRAM controller model, driven just after each rising edge.
    always @(posedge iCLK) begin
        #1;
        bus.rd_en   = (n_rd_acc < rd_goal) && (!gappy || $urandom_range(0, 3) != 0);
        bus.rd_addr = rd_base + AW'(n_rd_acc);
        bus.wr_en   = (n_wr_acc < wr_goal) && (!gappy || $urandom_range(0, 3) != 0);
        bus.wr_addr = wr_base + AW'(n_wr_acc);
        bus.wr_data = DW'(n_wr_acc * 40503 + 17);
        if (stall_at == n_rd_acc && stall_seen < stall_target) begin
            bus.sd_wait = 1'b1;
            stall_seen++;
        end else bus.sd_wait = rnd_wait && ($urandom_range(0, 3) == 0);
        if (ctrl_q.size() != 0 && (hold_rv ? rv_given < rv_allow : $urandom_range(0, 3) != 0)) begin
            bus.sd_rvalid = 1'b1;
            bus.sd_rdata  = rdat(ctrl_q.pop_front());
            rv_given++;
        end else begin
            bus.sd_rvalid = 1'b0;
            bus.sd_rdata  = DW'($urandom);
        end
    end

    // Reference model and scoreboards, sampled mid-cycle.
    always @(negedge iCLK) begin
        if (iRST) begin
            m_own = 0; m_burst = 0; m_pend = 0;
        end
        pok = m_pend < MAXP;
        ard = m_own == 1 && bus.rd_en && pok && !bus.sd_wait;
        awr = m_own == 2 && bus.wr_en && !bus.sd_wait;
        chk("grant", bus.grant, 64'(m_own));
        chk("pending", bus.pending, 64'(m_pend));
        chk("read_n", bus.sd_read_n, !(m_own == 1 && bus.rd_en && pok));
        chk("write_n", bus.sd_write_n, !(m_own == 2 && bus.wr_en));
        chk("rd_wait", bus.rd_wait, !(m_own == 1 && pok && !bus.sd_wait));
        chk("wr_wait", bus.wr_wait, !(m_own == 2 && !bus.sd_wait));
        chk("sd_addr", bus.sd_addr, m_own == 2 ? bus.wr_addr : bus.rd_addr);
        chk("sd_wdata", bus.sd_wdata, bus.wr_data);
        chk("rd_valid", bus.rd_valid, bus.sd_rvalid);
        chk("rd_data", bus.rd_data, bus.sd_rdata);
        if (bus.rd_en && !bus.rd_wait) begin
            exp_rd.push_back(rdat(bus.rd_addr));
            n_rd_acc++;
        end
        if (!bus.sd_read_n && !bus.sd_wait) ctrl_q.push_back(bus.sd_addr);
        if (bus.wr_en && !bus.wr_wait) begin
            exp_wr.push_back({bus.wr_addr, bus.wr_data});
            n_wr_acc++;
        end
        if (!bus.sd_write_n && !bus.sd_wait) begin
            n_wr_pulse++;
            chk("wr_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) chk("wr_cmd", {bus.sd_addr, bus.sd_wdata}, exp_wr.pop_front());
        end
        if (bus.rd_valid) begin
            if (stale_n > 0) stale_n--;
            else begin
                chk("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) chk("rd_return", bus.rd_data, exp_rd.pop_front());
            end
        end
        if (iRST) begin
            exp_rd.delete();
            exp_wr.delete();
            stale_n = ctrl_q.size();
        end else begin
            nown = m_own;
            if (m_own == 0) nown = bus.rd_en ? 1 : (bus.wr_en ? 2 : 0);
            else if (m_own == 1) nown = !bus.rd_en ? 0 : ((ard && m_burst + 1 >= LIM && bus.wr_en) ? 2 : 1);
            else nown = !bus.wr_en ? 0 : ((awr && m_burst + 1 >= LIM && bus.rd_en) ? 1 : 2);
            if (ard && !bus.sd_rvalid) m_pend++;
            else if (bus.sd_rvalid && !ard && m_pend > 0) m_pend--;
            if (nown != m_own) m_burst = 0;
            else if ((ard || awr) && m_burst < LIM) m_burst++;
            m_own = nown;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge iCLK);
        #2;
    endtask

    task automatic wait_rd(input int target);
        for (int t = 0; t < 3000 && n_rd_acc < target; t++) step(1);
        chk("rd_count", n_rd_acc, target);
    endtask

    task automatic wait_wr(input int target);
        for (int t = 0; t < 3000 && n_wr_acc < target; t++) step(1);
        chk("wr_count", n_wr_acc, target);
    endtask

    task automatic drain();
        for (int t = 0; t < 6000 && (n_rd_acc < rd_goal || n_wr_acc < wr_goal || ctrl_q.size() != 0); t++)
            step(1);
        step(3);
        chk("drain_ctrl_q", ctrl_q.size(), 0);
        chk("drain_grant", bus.grant, GNT_NONE);
        chk("drain_pending", bus.pending, 0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int r0, w0, p0;
        bus.rd_en = 0; bus.rd_addr = '0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.sd_wait = 0; bus.sd_rdata = '0; bus.sd_rvalid = 0;
        step(3);
        @(negedge iCLK);
        chk("rst_grant", bus.grant, GNT_NONE);
        chk("rst_read_n", bus.sd_read_n, 1);
        chk("rst_write_n", bus.sd_write_n, 1);
        chk("rst_rd_wait", bus.rd_wait, 1);
        chk("rst_wr_wait", bus.wr_wait, 1);
        step(1);
        iRST = 1'b0;
        // writer only, ten back-to-back writes
        w0 = n_wr_acc; p0 = n_wr_pulse;
        wr_goal += 10;
        wait_wr(w0 + 10);
        @(negedge iCLK);
        chk("wo_grant_wr", bus.grant, GNT_WR);
        @(negedge iCLK);
        chk("wo_grant_idle", bus.grant, GNT_NONE);
        chk("wo_pulses", n_wr_pulse - p0, 10);
        // simultaneous requests: reader wins
        step(2);
        rd_goal += 1; wr_goal += 1;
        step(1);
        @(negedge iCLK);
        chk("tie_idle", bus.grant, GNT_NONE);
        @(negedge iCLK);
        chk("tie_grant_rd", bus.grant, GNT_RD);
        chk("tie_wr_stall", bus.wr_wait, 1);
        drain();
        // both held: 32-command bursts alternate
        r0 = n_rd_acc; w0 = n_wr_acc;
        rd_goal += 64; wr_goal += 64;
        wait_rd(r0 + LIM);
        chk("burst_to_wr", bus.grant, GNT_WR);
        wait_wr(w0 + LIM);
        chk("burst_to_rd", bus.grant, GNT_RD);
        chk("burst_rd_held", n_rd_acc, r0 + LIM);
        drain();
        // controller withholds read data: pending cap
        hold_rv = 1'b1; rv_allow = rv_given;
        r0 = n_rd_acc;
        rd_goal += 10;
        step(14);
        @(negedge iCLK);
        chk("cap_reads", n_rd_acc, r0 + MAXP);
        chk("cap_pending", bus.pending, MAXP);
        chk("cap_read_n", bus.sd_read_n, 1);
        chk("cap_rd_wait", bus.rd_wait, 1);
        chk("cap_grant", bus.grant, GNT_RD);
        step(1);
        rv_allow = rv_given + 1;
        step(5);
        chk("cap_one_more", n_rd_acc, r0 + MAXP + 1);
        chk("cap_pending2", bus.pending, MAXP);
        hold_rv = 1'b0;
        drain();
        // controller stall on the last read of a burst
        r0 = n_rd_acc;
        stall_at = r0 + LIM - 1; stall_target = stall_seen + 5;
        rd_goal += 40; wr_goal += 40;
        wait_rd(r0 + LIM - 1);
        repeat (5) begin
            @(negedge iCLK);
            chk("stall_grant", bus.grant, GNT_RD);
            chk("stall_reads", n_rd_acc, r0 + LIM - 1);
        end
        wait_rd(r0 + LIM);
        chk("stall_switch", bus.grant, GNT_WR);
        stall_at = -1;
        drain();
        // reset with five reads outstanding
        hold_rv = 1'b1; rv_allow = rv_given;
        r0 = n_rd_acc;
        rd_goal += 5;
        wait_rd(r0 + 5);
        step(1);
        chk("rst_pending5", bus.pending, 5);
        iRST = 1'b1;
        wr_goal += 3;
        step(1);
        @(negedge iCLK);
        chk("mrst_grant", bus.grant, GNT_NONE);
        chk("mrst_pending", bus.pending, 0);
        chk("mrst_read_n", bus.sd_read_n, 1);
        chk("mrst_write_n", bus.sd_write_n, 1);
        chk("mrst_rd_wait", bus.rd_wait, 1);
        chk("mrst_wr_wait", bus.wr_wait, 1);
        step(1);
        iRST = 1'b0;
        @(negedge iCLK);
        chk("mrst_release_pending", bus.pending, 0);
        hold_rv = 1'b0;
        drain();
        chk("stale_forwarded", stale_n, 0);
        // randomized traffic with controller stalls and requester gaps
        gappy = 1'b1; rnd_wait = 1'b1;
        rd_goal += 150; wr_goal += 150;
        drain();
        chk("sb_rd_empty", exp_rd.size(), 0);
        chk("sb_wr_empty", exp_wr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- ADDR_W, 25, SDRAM word address width.
- DATA_W, 16, SDRAM data width.
- MAX_PENDING, 8, maximum outstanding reads.
- RD_BURST_LIMIT, 32, read commands accepted before a waiting writer forces a switch.
- WR_BURST_LIMIT, 32, write commands accepted before a waiting reader forces a switch.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), with one clock and an asynchronous, active-high reset:
- iCLK, in, 1, SDRAM controller clock.
- iRST, in, 1, asynchronous active-high reset.
- iRD_EN, in, 1, reader command valid.
- iRD_ADDR, in, ADDR_W, reader address.
- oRD_WAIT_REQUEST, out, 1, reader stall.
- oRD_DATA, out, DATA_W, read data.
- oRD_DATAVALID, out, 1, read data valid.
- iWR_EN, in, 1, writer command valid.
- iWR_ADDR, in, ADDR_W, writer address.
- iWR_DATA, in, DATA_W, writer data.
- oWR_WAIT_REQUEST, out, 1, writer stall.
- oSDRAM_ADDR, out, ADDR_W, controller address.
- oSDRAM_READ_N, out, 1, controller read strobe, active low.
- oSDRAM_WRITE_N, out, 1, controller write strobe, active low.
- oSDRAM_WRITEDATA, out, DATA_W, controller write data.
- iSDRAM_WAIT_REQUEST, in, 1, controller stall.
- iSDRAM_READDATA, in, DATA_W, controller read data.
- iSDRAM_READDATAVALID, in, 1, controller read data valid.
- oGRANT, out, 2, current owner: 00 none, 01 reader, 10 writer.
- oPENDING, out, 4, outstanding read count.

Function
REQ-003 The grant FSM SHALL have the states IDLE, GRANT_RD and GRANT_WR; the state is registered, so a grant takes effect one cycle after a request is seen in IDLE.

REQ-004 In IDLE, iRD_EN SHALL lead to GRANT_RD, else iWR_EN SHALL lead to GRANT_WR, else the FSM stays in IDLE; the reader wins when both requesters are active.

REQ-005 An accepted read SHALL be state==GRANT_RD & iRD_EN & pending<MAX_PENDING & !iSDRAM_WAIT_REQUEST; an accepted write SHALL be state==GRANT_WR & iWR_EN & !iSDRAM_WAIT_REQUEST.

REQ-006 oSDRAM_READ_N SHALL be low iff state==GRANT_RD & iRD_EN & pending<MAX_PENDING; oSDRAM_WRITE_N SHALL be low iff state==GRANT_WR & iWR_EN; both outputs are combinational.

REQ-007 oSDRAM_ADDR SHALL equal iWR_ADDR in GRANT_WR and iRD_ADDR otherwise; oSDRAM_WRITEDATA SHALL equal iWR_DATA.

REQ-008 oRD_WAIT_REQUEST SHALL be high unless state==GRANT_RD & pending<MAX_PENDING & !iSDRAM_WAIT_REQUEST; oWR_WAIT_REQUEST SHALL be high unless state==GRANT_WR & !iSDRAM_WAIT_REQUEST.

REQ-009 oRD_DATA and oRD_DATAVALID SHALL pass iSDRAM_READDATA and iSDRAM_READDATAVALID through combinationally, independent of grant.

REQ-010 The pending counter SHALL increment on an accepted read, decrement on iSDRAM_READDATAVALID, stay unchanged when both occur in the same cycle, and never wrap.

REQ-011 A burst counter SHALL clear on every state change and increment on each accepted command, saturating at its limit.

REQ-012 GRANT_RD SHALL go to IDLE when iRD_EN is low, and to GRANT_WR on the cycle of an accepted read that brings the burst count to RD_BURST_LIMIT while iWR_EN is high.

REQ-013 GRANT_WR SHALL behave symmetrically, using WR_BURST_LIMIT and iRD_EN.

REQ-014 The grant SHALL never change while a command is presented and stalled (en high, iSDRAM_WAIT_REQUEST high).

REQ-015 Leaving GRANT_RD with pending>0 is permitted; read data that returns after the switch SHALL still be delivered through oRD_DATAVALID.

REQ-016 When pending==MAX_PENDING in GRANT_RD, the reader SHALL stall and the grant SHALL be kept; if iRD_EN drops, the normal transition to IDLE applies.

Reset
REQ-017 While iRST is high the block SHALL force: state IDLE, pending 0, burst counter 0, oGRANT 00, oSDRAM_READ_N 1, oSDRAM_WRITE_N 1, oRD_WAIT_REQUEST 1, oWR_WAIT_REQUEST 1.

REQ-018 A reset asserted mid-burst SHALL abandon all outstanding reads; any datavalid arriving after reset release with pending==0 SHALL be forwarded and SHALL NOT decrement the pending counter.

Structure
REQ-019 The grant-state encoding and the oGRANT codes SHALL live in a shared package (sdram_arb_pkg), as SHALL default widths matching the 25-bit/16-bit controller.

REQ-020 The read/write grant paths SHALL be handled inline; one sub-module, sat_counter (parameterised width, saturating up/down), SHALL implement both the pending counter and the burst counter.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Writer only, 10 writes, no stall -> 10 WRITE_N pulses at consecutive addresses, oGRANT=10, then IDLE one cycle after iWR_EN falls.
- iRD_EN and iWR_EN rise on the same cycle -> oGRANT=01 on the next cycle, writer stalled.
- Both held continuously -> exactly 32 reads accepted, then oGRANT=10 on the following cycle, 32 writes, then back to 01.
- Controller withholds readdatavalid for 12 cycles -> after 8 accepted reads READ_N stays high and oRD_WAIT_REQUEST stays high; one datavalid -> next read accepted.
- iSDRAM_WAIT_REQUEST held for 5 cycles during the 32nd read -> no grant switch until that read is accepted.
- iRST pulsed with pending=5 -> all outputs at reset values; pending=0 after release.
